// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes and a restoring shift-subtract divider.
// Single-cycle ops finish on acceptance; DIV/MOD with a non-zero divisor iterate WIDTH cycles.
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [4:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             branch_taken_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             div_by_zero_o
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, res_q, res_d;
    logic             is_mod_q, is_mod_d, br_q, br_d, cy_q, cy_d, ov_q, ov_d, dz_q, dz_d;
    logic [WIDTH-1:0] res_c, rem_n, quo_n;
    logic             br_c, cy_c, ov_c, dz_c, accept, start_div;
    logic [WIDTH:0]   add_w, sub_w, shifted, trial;

    assign in_ready_o  = !reset_i && (state_q == IDLE || (state_q == DONE && out_ready_i));
    assign accept      = in_valid_i && in_ready_o;
    assign start_div   = op_i[4:1] == 4'b0111 && b_i != '0;
    assign add_w       = {1'b0, a_i} + {1'b0, b_i};
    assign sub_w       = {1'b0, a_i} - {1'b0, b_i};
    assign shifted     = {rem_q, quo_q[WIDTH-1]};
    assign trial       = shifted - {1'b0, dvs_q};
    assign rem_n       = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_n       = {quo_q[WIDTH-2:0], !trial[WIDTH]};
    assign out_valid_o    = state_q == DONE;
    assign result_o       = res_q;
    assign branch_taken_o = br_q;
    assign carry_o        = cy_q;
    assign overflow_o     = ov_q;
    assign div_by_zero_o  = dz_q;

    // Result of every op that completes on acceptance; DIV/MOD entries only matter when b is zero.
    always_comb begin
        res_c = '0;
        br_c  = 1'b0;
        cy_c  = 1'b0;
        ov_c  = 1'b0;
        dz_c  = 1'b0;
        casez (op_i)
            5'b00000, 5'b100??: begin
                res_c = add_w[WIDTH-1:0];
                cy_c  = add_w[WIDTH];
                ov_c  = a_i[WIDTH-1] == b_i[WIDTH-1] && add_w[WIDTH-1] != a_i[WIDTH-1];
            end
            5'b00001: begin
                res_c = sub_w[WIDTH-1:0];
                cy_c  = sub_w[WIDTH];
                ov_c  = a_i[WIDTH-1] != b_i[WIDTH-1] && sub_w[WIDTH-1] != a_i[WIDTH-1];
            end
            5'b01000: begin
                res_c = sub_w[WIDTH-1:0];
                cy_c  = sub_w[WIDTH];
            end
            5'b01001: begin
                res_c = add_w[WIDTH-1:0];
                cy_c  = add_w[WIDTH];
            end
            5'b00010: res_c = a_i << b_i;
            5'b00011: res_c = a_i >> b_i;
            5'b00111: res_c = WIDTH'($signed(a_i) < $signed(b_i));
            5'b01010: res_c = a_i & b_i;
            5'b01100: res_c = WIDTH'(a_i == b_i);
            5'b01110: begin
                res_c = '1;
                dz_c  = 1'b1;
            end
            5'b01111: begin
                res_c = a_i;
                dz_c  = 1'b1;
            end
            5'b101??: begin
                br_c  = a_i != '0;
                res_c = br_c ? b_i : '0;
            end
            5'b110??: begin
                br_c  = a_i == '0;
                res_c = br_c ? b_i : '0;
            end
            5'b111??: res_c = b_i;
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        is_mod_d = is_mod_q;
        res_d    = res_q;
        br_d     = br_q;
        cy_d     = cy_q;
        ov_d     = ov_q;
        dz_d     = dz_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept && start_div) begin
                    state_d  = DIVIDE;
                    cnt_d    = CW'(WIDTH);
                    rem_d    = '0;
                    quo_d    = a_i;
                    dvs_d    = b_i;
                    is_mod_d = op_i[0];
                end else if (accept) begin
                    state_d = DONE;
                    res_d   = res_c;
                    br_d    = br_c;
                    cy_d    = cy_c;
                    ov_d    = ov_c;
                    dz_d    = dz_c;
                end else if (state_q == DONE && out_ready_i) begin
                    state_d = IDLE;
                end
            end
            DIVIDE: begin
                cnt_d = cnt_q - CW'(1);
                rem_d = rem_n;
                quo_d = quo_n;
                // The last iteration's quotient/remainder go straight into the output registers.
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    res_d   = is_mod_q ? rem_n : quo_n;
                    br_d    = 1'b0;
                    cy_d    = 1'b0;
                    ov_d    = 1'b0;
                    dz_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            is_mod_q <= 1'b0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cy_q     <= 1'b0;
            ov_q     <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            is_mod_q <= is_mod_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cy_q     <= cy_d;
            ov_q     <= ov_d;
            dz_q     <= dz_d;
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench driving an 8-bit and a 16-bit alu_mc against an integer reference model.
module tb_alu_mc;
    typedef struct {
        logic [4:0]  op;
        logic [15:0] res;
        logic        br, cy, ov, dz;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 0, rst = 0;
    logic [1:0] iv = '0, ordy = '0;
    logic [1:0][4:0] op = '0;
    logic [1:0][15:0] a = '0, b = '0;
    wire [1:0] irdy, ovld, brt, cyo, ovf, dbz;
    wire [1:0][15:0] res_w;
    int cyc = 0, checks = 0, passed = 0;
    bit rnd_rdy = 0;
    bit seen [2];
    exp_t cur [2];
    exp_t rec;
    exp_t sb [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rnd_rdy) ordy <= 2'($urandom);

    alu_mc #(.WIDTH(8)) u8 (
        .clk_i(clk), .reset_i(rst), .in_valid_i(iv[0]), .in_ready_o(irdy[0]), .op_i(op[0]),
        .a_i(a[0][7:0]), .b_i(b[0][7:0]), .out_valid_o(ovld[0]), .out_ready_i(ordy[0]),
        .result_o(res_w[0][7:0]), .branch_taken_o(brt[0]), .carry_o(cyo[0]),
        .overflow_o(ovf[0]), .div_by_zero_o(dbz[0]));
    assign res_w[0][15:8] = '0;

    alu_mc #(.WIDTH(16)) u16 (
        .clk_i(clk), .reset_i(rst), .in_valid_i(iv[1]), .in_ready_o(irdy[1]), .op_i(op[1]),
        .a_i(a[1]), .b_i(b[1]), .out_valid_o(ovld[1]), .out_ready_i(ordy[1]),
        .result_o(res_w[1]), .branch_taken_o(brt[1]), .carry_o(cyo[1]),
        .overflow_o(ovf[1]), .div_by_zero_o(dbz[1]));

    function automatic int wd(int d);
        return d == 0 ? 8 : 16;
    endfunction

    // Reference: plain integer arithmetic on the opcode table, reduced modulo 2^w at the end.
    function automatic exp_t model(int w, logic [4:0] o, longint x, longint y);
        exp_t e;
        longint m, hi, sx, sy, r;
        m  = (longint'(1) << w) - 1;
        hi = m >> 1;
        sx = x > hi ? x - m - 1 : x;
        sy = y > hi ? y - m - 1 : y;
        e.op = o; e.br = 0; e.cy = 0; e.ov = 0; e.dz = 0; e.lat = 1; e.acc = 0;
        r = 0;
        if (o == 5'd0 || o[4:2] == 3'b100) begin
            r = x + y; e.cy = r > m; e.ov = sx + sy > hi || sx + sy < -hi - 1;
        end else if (o == 5'd9) begin
            r = x + y; e.cy = r > m;
        end else if (o == 5'd1) begin
            r = x - y; e.cy = x < y; e.ov = sx - sy > hi || sx - sy < -hi - 1;
        end else if (o == 5'd8) begin
            r = x - y; e.cy = x < y;
        end else if (o == 5'd2) r = y >= w ? 0 : x << y;
        else if (o == 5'd3) r = y >= w ? 0 : x >> y;
        else if (o == 5'd7) r = sx < sy ? 1 : 0;
        else if (o == 5'd10) r = x & y;
        else if (o == 5'd12) r = x == y ? 1 : 0;
        else if (o == 5'd14 || o == 5'd15) begin
            e.dz = y == 0;
            if (y == 0) r = o[0] ? x : m;
            else begin
                r = o[0] ? x % y : x / y;
                e.lat = w + 1;
            end
        end else if (o[4:2] == 3'b101 || o[4:2] == 3'b110) begin
            e.br = (x != 0) == (o[4:2] == 3'b101);
            r = e.br ? y : 0;
        end else if (o[4:2] == 3'b111) r = y;
        e.res = 16'(r & m);
        return e;
    endfunction

    task automatic chk(string n, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h want %0h", n, got, want);
    endtask

    function automatic string nm(int d, string s);
        return $sformatf("d%0d_op%05b_%s", d, cur[d].op, s);
    endfunction

    // Monitor first (pops on each new presentation), then record any acceptance at the coming edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst && ovld[d]) begin
                if (!seen[d]) begin
                    if (sb[d].size() == 0) chk($sformatf("d%0d_unexpected_output", d), 1, 0);
                    else begin
                        cur[d] = sb[d].pop_front();
                        seen[d] = 1;
                        chk(nm(d, "latency"), cyc - cur[d].acc, cur[d].lat);
                        chk(nm(d, "result"), res_w[d], cur[d].res);
                        chk(nm(d, "branch"), brt[d], cur[d].br);
                        chk(nm(d, "carry"), cyo[d], cur[d].cy);
                        chk(nm(d, "overflow"), ovf[d], cur[d].ov);
                        chk(nm(d, "divzero"), dbz[d], cur[d].dz);
                    end
                end else chk(nm(d, "hold"), res_w[d], cur[d].res);
                if (!ordy[d]) chk(nm(d, "stall_ready"), irdy[d], 0);
                else seen[d] = 0;
            end
            if (!rst && iv[d] && irdy[d]) begin
                rec = model(wd(d), op[d], a[d], b[d]);
                rec.acc = cyc;
                sb[d].push_back(rec);
            end
        end
    end

    // Called and returns just after a rising edge; in_valid stays high on return.
    task automatic issue(int d, logic [4:0] o, logic [15:0] x, logic [15:0] y, output int waits);
        iv[d] = 1; op[d] = o; a[d] = x; b[d] = y; waits = 0;
        @(negedge clk);
        while (!irdy[d] && waits < 300) begin
            waits++;
            @(negedge clk);
        end
        if (!irdy[d]) chk($sformatf("d%0d_accept_timeout", d), 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb[0].size() + sb[1].size() != 0 || seen[0] || seen[1]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n == 2000) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_run(int d);
        int w, wt;
        logic [15:0] m, x, y;
        w = wd(d);
        m = 16'((32'd1 << w) - 1);
        for (int i = 0; i < 150; i++) begin
            x = 16'($urandom) & m;
            y = $urandom_range(0, 2) == 0 ? 16'($urandom_range(0, w + 1)) : 16'($urandom) & m;
            issue(d, 5'($urandom_range(0, 31)), x, y, wt);
            if ($urandom_range(0, 4) == 0) begin
                iv[d] = 0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        iv[d] = 0;
    endtask

    initial begin
        int w;
        logic [4:0] b2b_ops [6];
        b2b_ops = '{5'b00000, 5'b00001, 5'b01010, 5'b01100, 5'b10011, 5'b11111};
        #1 rst = 1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_rst_valid", d), ovld[d], 0);
            chk($sformatf("d%0d_rst_result", d), res_w[d], 0);
            chk($sformatf("d%0d_rst_flags", d), {brt[d], cyo[d], ovf[d], dbz[d]}, 0);
        end
        @(posedge clk);
        #1 rst = 0; ordy = 2'b11;
        @(negedge clk);
        chk("d0_idle_ready", irdy[0], 1);
        chk("d1_idle_ready", irdy[1], 1);
        @(posedge clk);
        #1;
        issue(0, 5'b00000, 'h7F, 'h01, w);
        issue(0, 5'b01001, 'hFF, 'h01, w);
        issue(0, 5'b01110, 200, 7, w);
        issue(0, 5'b01111, 200, 7, w);
        issue(0, 5'b01111, 5, 0, w);
        issue(0, 5'b10100, 0, 'h12, w);
        issue(0, 5'b11000, 0, 'h12, w);
        issue(0, 5'b00111, 'hFF, 'h01, w);
        iv[0] = 0;
        issue(1, 5'b00010, 'h0001, 15, w);
        issue(1, 5'b00010, 'h0001, 16, w);
        issue(1, 5'b01110, 'hFFFF, 'h0100, w);
        iv[1] = 0;
        wait_idle();
        for (int i = 0; i < 6; i++) begin
            issue(0, b2b_ops[i], 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), w);
            chk($sformatf("d0_b2b_wait_%0d", i), w, 0);
        end
        iv[0] = 0;
        wait_idle();
        ordy[0] = 0;
        issue(0, 5'b00000, 'h12, 'h34, w);
        iv[0] = 1; op[0] = 5'b00001; a[0] = 'h50; b[0] = 'h20;
        repeat (6) @(posedge clk);
        #1 ordy[0] = 1;
        @(negedge clk);
        chk("d0_accept_on_consume", irdy[0], 1);
        @(posedge clk);
        #1 iv[0] = 0;
        wait_idle();
        issue(0, 5'b01110, 255, 3, w);
        iv[0] = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1;
        #1;
        chk("d0_abort_valid", ovld[0], 0);
        chk("d0_abort_result", res_w[0], 0);
        chk("d0_abort_flags", {brt[0], cyo[0], ovf[0], dbz[0]}, 0);
        sb[0].delete();
        seen[0] = 0;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("d0_post_reset_ready", irdy[0], 1);
        chk("d0_post_reset_valid", ovld[0], 0);
        @(posedge clk);
        #1;
        issue(0, 5'b01100, 9, 9, w);
        iv[0] = 0;
        wait_idle();
        rnd_rdy = 1;
        fork
            rand_run(0);
            rand_run(1);
        join
        rnd_rdy = 0;
        @(posedge clk);
        #2 ordy = 2'b11;
        wait_idle();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, width-parametrised ALU for the datapath. It replaces the single-cycle 8-bit ALU and keeps its 5-bit opcode map. It adds unsigned DIV and an iterative MOD, carry, overflow and divide-by-zero flags, and a corrected branch-compare output. Operands enter through a valid/ready handshake. Results are held on a valid/ready output port until the control unit consumes them.

## Interface
- WIDTH, 8, operand/result width in bits (≥4)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  operation presented
- in_ready  out  1  operation accepted when in_valid & in_ready at rising clk
- op  in  5  opcode
- a  in  WIDTH  operand one (rs / branch test value)
- b  in  WIDTH  operand two (rt / immediate / branch target)
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer takes result when out_valid & out_ready
- result  out  WIDTH  operation result
- branch_taken  out  1  branch condition met (BNE/BEZ only)
- carry  out  1  carry-out (ADD/ADDU/ADDI), borrow (SUB/SUBU)
- overflow  out  1  signed overflow (ADD/SUB/ADDI)
- div_by_zero  out  1  DIV/MOD with b==0

## Operation
- Opcodes:
  - ADD 00000, SUB 00001, SLL 00010, SRL 00011, SLT 00111 (signed a<b → 1)
  - SUBU 01000, ADDU 01001, AND 01010, SEZ 01011 (→0), SEQ 01100 (a==b → 1)
  - DIV 01110 (unsigned a/b), MOD 01111 (unsigned a%b)
  - ADDI 100xx, BNE 101xx, BEZ 110xx, MV 111xx (→b)
- Arithmetic is modulo 2^WIDTH.
  - SUBU/ADDU produce the same result as SUB/ADD, but only carry is meaningful; overflow=0.
- SLL/SRL: shift amount is the full unsigned b. If b≥WIDTH, result=0.
- BNE: branch_taken=(a!=0). BEZ: branch_taken=(a==0). For both, result=b when taken, else 0.
- Flags not defined for an op are 0. Undefined opcodes (00100, 00101, 00110, 01101) give result=0 and all flags 0.
- DIV/MOD use restoring shift-subtract division, one quotient bit per cycle, WIDTH iterations.
- b==0:
  - No iteration; completes like a single-cycle op.
  - div_by_zero=1.
  - DIV result = all ones; MOD result = a.
- Operands and op are registered on acceptance. Input changes after acceptance have no effect.
- FSM:
  - IDLE: in_ready=1. On accept, go to DIVIDE if op is DIV/MOD with b≠0; otherwise compute, register outputs, and go to DONE.
  - DIVIDE: in_ready=0. Count down from WIDTH. When the count is exhausted, register outputs and go to DONE.
  - DONE: out_valid=1; result and flags stable.
    - out_ready=1 with no accept: go to IDLE.
    - in_ready = out_ready. A new accept in the same cycle as consumption starts the next op directly (to DIVIDE or DONE) without passing through IDLE.
- Reset (any state, including mid-DIVIDE) aborts the op and enters IDLE.
  - out_valid, result, branch_taken, carry, overflow, div_by_zero all go to 0.
  - in_ready=1 while reset is deasserted and in IDLE.

## Timing
- All outputs are registered. No combinational path from the inputs to result or flags.
- in_ready depends combinationally on out_ready in DONE only.
- Single-cycle ops and b==0 DIV/MOD: accept at edge k → out_valid high after edge k+1.
- DIV/MOD with b≠0: accept at edge k → out_valid high after edge k+1+WIDTH.
- Back-to-back single-cycle ops with out_ready held at 1: one result per cycle.
- Stall: if out_ready=0, result and flags hold indefinitely and in_ready=0.
- Reset assertion takes effect immediately (asynchronous). Deassertion is sampled at the next rising clk.

## Test plan
- WIDTH=8: ADD a=0x7F, b=0x01 → result=0x80, overflow=1, carry=0. ADDU a=0xFF, b=0x01 → result=0x00, carry=1. Each has out_valid one cycle after accept.
- DIV a=200, b=7 → result=28 exactly 9 cycles after accept. MOD a=200, b=7 → 4. MOD a=5, b=0 → result=5, div_by_zero=1, latency 1.
- BNE a=0, b=0x12 → branch_taken=0, result=0. BEZ a=0, b=0x12 → branch_taken=1, result=0x12. SLT a=0xFF, b=0x01 → 1 (signed).
- Hold out_ready=0 after an ADD completes while in_valid stays high → in_ready=0 and result stable for 5 cycles. Raise out_ready → the next op is accepted in the same cycle.
- Assert reset 3 cycles into DIV a=255, b=3 → all outputs 0 and in_ready=1 after release. A following SEQ a=9, b=9 → result=1.
- WIDTH=16: SLL a=0x0001, b=15 → 0x8000. SLL b=16 → 0. DIV a=0xFFFF, b=0x0100 → 0x00FF after 17 cycles.
